stonyman_frame_sequencer: RTL
=============================

Name: stonyman_frame_sequencer

Overview:
- Parametrised successor of the single-camera capture path.
- Drives the pixel-addressing pulses (resv/resp/incv/incp/inphi) of NUM_CAM Stonyman-style vision chips sharing one pixel pointer.
- Reads every pixel through serial ADCs that share CS/SCLK and have one MISO per camera.
- Packs all cameras' samples for a pixel into one FIFO word. It sits between the APB-controlled start/status register and the capture FIFO, and adds row/column windowing, continuous mode and FIFO back-pressure.

Parameters:
- ROWS, 112, rows read per frame (1..255)
- COLS, 112, columns read per frame (1..255)
- NUM_CAM, 1, cameras/ADCs read in parallel (1..4)
- ADC_BITS, 10, sample bits per conversion
- FRAME_BITS, 16, SCLK cycles per conversion
- LEAD_BITS, 3, SCLK cycles before the sample MSB
- SCLK_DIV, 2, SYSCLK cycles per SCLK half-period (>=1)
- PULSE_CYCLES, 2, high time of each control pulse in SYSCLK cycles (>=1)
- SETTLE_CYCLES, 8, wait after pointer change before a conversion starts (>=1)

Ports:
- SYSCLK  in  1  system clock, only clock
- SYSRESET  in  1  synchronous reset, active high
- start_capture  in  1  one-cycle start request
- continuous  in  1  sampled at frame end: 1 starts the next frame, 0 stops
- stop_req  in  1  level: finish current frame, then go idle
- fifo_full  in  1  capture FIFO full
- fifo_wren  out  1  one-cycle write strobe
- fifo_wdata  out  NUM_CAM*ADC_BITS  camera k in bits [k*ADC_BITS +: ADC_BITS]
- busy  out  1  high from accepted start until return to IDLE
- frame_done  out  1  one-cycle pulse after the last pixel write of a frame
- resp, incp, resv, incv, inphi  out  1 each  sensor control pulses
- CS  out  1  ADC chip select, active low
- SCLK  out  1  ADC serial clock, idle high
- MISO  in  NUM_CAM  ADC data, one bit per camera

Behaviour:
- Reset (synchronous, active high; checked every cycle, overrides all activity):
  - State returns to IDLE and all counters clear.
  - CS=1, SCLK=1. All pulses, fifo_wren, busy and frame_done are 0. fifo_wdata=0.
  - A mid-frame reset abandons the frame with no partial FIFO write.
- States: IDLE -> RSTV -> RSTP -> SETTLE -> CONV -> WAITF -> WRITE -> INCP -> (SETTLE | INCV) -> ... -> DONE.
- IDLE:
  - start_capture=1 is accepted; busy goes high the next cycle.
  - start_capture outside IDLE is ignored.
- RSTV: resv high for PULSE_CYCLES. RSTP: resp high for PULSE_CYCLES.
- SETTLE: SETTLE_CYCLES idle cycles; inphi held high here and in CONV.
- CONV:
  - CS is low for exactly FRAME_BITS SCLK periods; SCLK period is 2*SCLK_DIV.
  - SCLK falls first. MISO[k] is sampled on each SCLK rising edge.
  - Sample bits are SCLK rising edges LEAD_BITS+1 .. LEAD_BITS+ADC_BITS, MSB first. Other bits are ignored.
  - CS returns high one cycle after the last rising edge.
- WAITF: holds while fifo_full=1 (no data loss, sensor pointer frozen), then goes to WRITE.
- WRITE: fifo_wren=1 for exactly one cycle with the packed word.
- INCP:
  - incp pulse for PULSE_CYCLES.
  - If col < COLS-1: col++, go to SETTLE.
  - Otherwise: col=0 and go to INCV.
- INCV:
  - incv pulse, then resp pulse (restarts the column pointer).
  - If row < ROWS-1: row++, go to SETTLE.
  - Otherwise go to DONE.
- DONE:
  - frame_done pulses for one cycle.
  - continuous=1 and stop_req=0: go to RSTV.
  - Otherwise: go to IDLE and drop busy the same cycle.
- Pulses never overlap; at most one of resp/incp/resv/incv is high in any cycle.
- Writes per frame = ROWS*COLS exactly. Row/column counters wrap to 0 only via the reset pulses.

Test Plan:
1. Baseline frame.
   - Params: ROWS=2, COLS=3, NUM_CAM=2, ADC_BITS=10, FRAME_BITS=16, LEAD_BITS=3, SCLK_DIV=2, PULSE_CYCLES=2, SETTLE_CYCLES=4.
   - ADC models return cam0=0x155 and cam1=0x2AA.
   - Single start -> 6 writes, each fifo_wdata=0xAA955. Counts: incp=6, incv=2, resv=1, resp=3. One frame_done, then busy=0.
2. Serial timing.
   - Same params, single pixel window.
   - Required: CS low for 64 SYSCLK cycles; 16 SCLK rising edges; SCLK high whenever CS=1; captured bits are rising edges 4..13.
3. Back-pressure.
   - Hold fifo_full=1 for 50 cycles at the 3rd pixel.
   - Required: fifo_wren stays 0 and no incp occurs while full. The write follows 1 cycle after release. Data is unchanged and the total is still 6 writes.
4. Continuous mode.
   - continuous=1; assert stop_req during frame 3.
   - Required: 3 frame_done pulses, 18 writes, busy never drops between frames, idle after frame 3.
5. Reset mid-conversion.
   - Assert SYSRESET while CS=0.
   - Required: the next cycle has CS=1, SCLK=1, busy=0 and no fifo_wren. A new start gives a full correct frame.
6. Ignored start.
   - Pulse start_capture while busy.
   - Required: no restart; write count unchanged.

Source files
------------

// File: rtl/stonyman_frame_sequencer.sv
// Frame sequencer for NUM_CAM Stonyman vision chips sharing one pixel pointer.
// Walks the pixel window, reads each pixel over serial ADCs and packs the samples into one FIFO word.
module stonyman_frame_sequencer #(
    parameter int ROWS          = 112,
    parameter int COLS          = 112,
    parameter int NUM_CAM       = 1,
    parameter int ADC_BITS      = 10,
    parameter int FRAME_BITS    = 16,
    parameter int LEAD_BITS     = 3,
    parameter int SCLK_DIV      = 2,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                         SYSCLK,
    input  logic                         SYSRESET,
    input  logic                         start_capture,
    input  logic                         continuous,
    input  logic                         stop_req,
    input  logic                         fifo_full,
    output logic                         fifo_wren,
    output logic [NUM_CAM*ADC_BITS-1:0]  fifo_wdata,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         resp,
    output logic                         incp,
    output logic                         resv,
    output logic                         incv,
    output logic                         inphi,
    output logic                         CS,
    output logic                         SCLK,
    input  logic [NUM_CAM-1:0]           MISO
);

    localparam int CONV_CYCLES = 2 * SCLK_DIV * FRAME_BITS;
    localparam int WAIT_MAX    = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW          = $clog2(WAIT_MAX + 1);
    localparam int VW          = $clog2(CONV_CYCLES + 1);
    localparam int HW          = $clog2(SCLK_DIV + 1);
    localparam int RW          = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] CONV_LAST   = VW'(CONV_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LAST   = HW'(SCLK_DIV - 1);
    localparam logic [RW-1:0] BIT_FIRST   = RW'(LEAD_BITS + 1);
    localparam logic [RW-1:0] BIT_LAST    = RW'(LEAD_BITS + ADC_BITS);
    localparam logic [7:0]    ROW_LAST    = 8'(ROWS - 1);
    localparam logic [7:0]    COL_LAST    = 8'(COLS - 1);

    // The first SCLK half-period is shortened by one cycle so the last
    // rising edge lands on the final CS-low cycle.
    localparam logic          SCLK_INIT   = (SCLK_DIV != 1);
    localparam logic [HW-1:0] HALF_INIT   = (SCLK_DIV == 1) ? '0 : HW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RSTV,
        S_RSTP,
        S_SETTLE,
        S_CONV,
        S_WAITF,
        S_WRITE,
        S_INCP,
        S_INCV,
        S_RESP,
        S_DONE
    } state_t;

    state_t                             state;
    logic [CW-1:0]                      wcnt;
    logic [VW-1:0]                      ccnt;
    logic [HW-1:0]                      hcnt;
    logic [RW-1:0]                      rcnt;
    logic [RW-1:0]                      rnext;
    logic [7:0]                         row;
    logic [7:0]                         col;
    logic [NUM_CAM-1:0][ADC_BITS-1:0]   sh;

    assign rnext = rcnt + 1'b1;

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            ccnt       <= '0;
            hcnt       <= '0;
            rcnt       <= '0;
            row        <= '0;
            col        <= '0;
            sh         <= '0;
            fifo_wren  <= 1'b0;
            fifo_wdata <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            resp       <= 1'b0;
            incp       <= 1'b0;
            resv       <= 1'b0;
            incv       <= 1'b0;
            inphi      <= 1'b0;
            CS         <= 1'b1;
            SCLK       <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_capture) begin
                        busy  <= 1'b1;
                        resv  <= 1'b1;
                        wcnt  <= '0;
                        state <= S_RSTV;
                    end
                end
                S_RSTV: begin
                    if (wcnt == PULSE_LAST) begin
                        resv  <= 1'b0;
                        resp  <= 1'b1;
                        wcnt  <= '0;
                        state <= S_RSTP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_RSTP: begin
                    if (wcnt == PULSE_LAST) begin
                        resp  <= 1'b0;
                        inphi <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        wcnt  <= '0;
                        state <= S_SETTLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (wcnt == SETTLE_LAST) begin
                        CS    <= 1'b0;
                        SCLK  <= SCLK_INIT;
                        hcnt  <= HALF_INIT;
                        ccnt  <= '0;
                        rcnt  <= '0;
                        state <= S_CONV;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_CONV: begin
                    if (ccnt == CONV_LAST) begin
                        CS    <= 1'b1;
                        SCLK  <= 1'b1;
                        inphi <= 1'b0;
                        state <= S_WAITF;
                    end else begin
                        ccnt <= ccnt + 1'b1;
                        if (hcnt == HALF_LAST) begin
                            hcnt <= '0;
                            SCLK <= ~SCLK;
                            // MISO is taken on the cycle SCLK rises
                            if (!SCLK) begin
                                rcnt <= rnext;
                                if (rnext >= BIT_FIRST && rnext <= BIT_LAST) begin
                                    for (int k = 0; k < NUM_CAM; k++) begin
                                        sh[k] <= {sh[k][ADC_BITS-2:0], MISO[k]};
                                    end
                                end
                            end
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                S_WAITF: begin
                    if (!fifo_full) begin
                        fifo_wren  <= 1'b1;
                        fifo_wdata <= sh;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    fifo_wren <= 1'b0;
                    incp      <= 1'b1;
                    wcnt      <= '0;
                    state     <= S_INCP;
                end
                S_INCP: begin
                    if (wcnt == PULSE_LAST) begin
                        incp <= 1'b0;
                        wcnt <= '0;
                        if (col < COL_LAST) begin
                            col   <= col + 1'b1;
                            inphi <= 1'b1;
                            state <= S_SETTLE;
                        end else begin
                            col   <= '0;
                            incv  <= 1'b1;
                            state <= S_INCV;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_INCV: begin
                    if (wcnt == PULSE_LAST) begin
                        incv  <= 1'b0;
                        resp  <= 1'b1;
                        wcnt  <= '0;
                        state <= S_RESP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (wcnt == PULSE_LAST) begin
                        resp <= 1'b0;
                        wcnt <= '0;
                        if (row < ROW_LAST) begin
                            row   <= row + 1'b1;
                            inphi <= 1'b1;
                            state <= S_SETTLE;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    if (continuous && !stop_req) begin
                        resv  <= 1'b1;
                        wcnt  <= '0;
                        state <= S_RSTV;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
